irq_ctrl: RTL
=============

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, meaning number of interrupt sources; source index = priority, higher index wins.
REQ-002 SHALL have parameter MAX_DEPTH, default 3, meaning maximum nesting depth (fits o_irq_depth).
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_src, input, NUM_SRC, raw interrupt lines from peripherals (timer0 = bit 0, timer1 = bit 1).
REQ-006 SHALL have port i_irq_ack, input, 1, CPU takes the offered interrupt this cycle (CPU-side irq_take).
REQ-007 SHALL have port i_irq_ret, input, 1, CPU retires one handler (RETI) this cycle.
REQ-008 SHALL have port i_we, input, 1, register write strobe.
REQ-009 SHALL have port i_addr, input, 2, register select.
REQ-010 SHALL have port i_wdata, input, 16, register write data.
REQ-011 SHALL have port o_rdata, output, 16, combinational register read data.
REQ-012 SHALL have port o_irq_req, output, 1, an interrupt is offered to the CPU.
REQ-013 SHALL have port o_irq_vector, output, 16, handler address of the offered source.
REQ-014 SHALL have port o_in_irq, output, 1, high when depth is non-zero.
REQ-015 SHALL have port o_irq_depth, output, 2, current nesting depth.

Function
REQ-016 SHALL detect rising edges of i_src against a registered copy and set the matching PENDING bit on the following clock edge.
REQ-017 SHALL define vector = 16'h0020 + 16'h0020*index (source 0 -> 0x0020, source 1 -> 0x0040).
REQ-018 SHALL select the winner as the highest index with PENDING & ENABLE set.
REQ-019 SHALL derive o_irq_req and o_irq_vector combinationally from registered state, with zero added latency; o_irq_vector is 0x0000 when o_irq_req is low.
REQ-020 SHALL assert o_irq_req only when a winner exists, depth < MAX_DEPTH, and either depth = 0 or winner index > index on top of the active stack.
REQ-021 SHALL, on i_irq_ack with o_irq_req high, clear the winner's PENDING bit, push its index and increment depth.
REQ-022 SHALL ignore i_irq_ack while o_irq_req is low.
REQ-023 SHALL, on i_irq_ret with depth > 0, pop the stack and decrement depth; i_irq_ret at depth 0 is ignored.
REQ-024 SHALL, on simultaneous ack and ret, pop first and then push, leaving depth unchanged with the new index on top.
REQ-025 SHALL, on a new edge on the same source in the cycle its PENDING bit is cleared by ack, leave PENDING set (set wins).
REQ-026 SHALL use registers: addr 0 ENABLE (rw, bits NUM_SRC-1:0); addr 1 PENDING (read, write-1-to-clear); addr 2 STATUS (read: [1:0] depth, [7:4] top index); addr 3 reads 0.
REQ-027 SHALL, when a W1C register write and an edge set hit the same bit in the same cycle, leave the bit set.

Reset
REQ-028 SHALL, while i_rst_n is low, asynchronously clear ENABLE, PENDING, edge history, stack and depth.
REQ-029 SHALL, during reset, drive o_irq_req = 0, o_irq_vector = 0x0000, o_in_irq = 0, o_irq_depth = 0 and o_rdata = 0x0000 for all addresses.
REQ-030 SHALL, on reset asserted mid-handler, discard all nesting state; it does not require a matching ret after reset.

Configuration
REQ-031 SHALL, with macro IRQ_CTRL_NEST_EN defined, allow preemption up to MAX_DEPTH per REQ-020.
REQ-032 SHALL, without IRQ_CTRL_NEST_EN, assert o_irq_req only at depth 0, limit depth to 1, and hold the higher-priority source pending until ret.

Structure
REQ-033 SHALL take NUM_SRC default, vector base/stride, and register addresses from the shared package irq_pkg.
REQ-034 SHALL place winner selection in sub-module irq_prio_enc, a combinational highest-index priority encoder with a valid flag.

Verification
REQ-035 SHALL test: ENABLE = 0x3, rising edge on i_src[0] -> o_irq_req next cycle with vector 0x0020; ack -> depth 1, o_in_irq = 1.
REQ-036 SHALL test: at depth 1 servicing src0, edge on src1 -> vector 0x0040 offered; ack -> depth 2; two rets -> depth 0.
REQ-037 SHALL test: at depth 1 servicing src1, edge on src0 -> o_irq_req stays 0 until ret, then 0x0020 is offered.
REQ-038 SHALL test: without IRQ_CTRL_NEST_EN, src1 during src0 handler -> no request until ret; depth never exceeds 1.
REQ-039 SHALL test: ENABLE = 0x0, edge on src0 -> PENDING reads 0x0001 with no request; write 0x0001 to addr 1 -> PENDING reads 0x0000.
REQ-040 SHALL test: i_rst_n pulsed low at depth 2 -> all outputs 0 immediately; ret at depth 0 -> no change.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: source count, vector map and register map.
package irq_pkg;
  localparam int          NUM_SRC_DEF   = 4;
  localparam int          MAX_DEPTH_DEF = 3;
  localparam logic [15:0] VEC_BASE      = 16'h0020;
  localparam logic [15:0] VEC_STRIDE    = 16'h0020;

  typedef enum logic [1:0] {
    ADDR_ENABLE  = 2'd0,
    ADDR_PENDING = 2'd1,
    ADDR_STATUS  = 2'd2,
    ADDR_RSVD    = 2'd3
  } reg_addr_e;

  function automatic logic [15:0] vec_of(input logic [15:0] idx);
    return VEC_BASE + VEC_STRIDE * idx;
  endfunction
endpackage

// File: rtl/irq_ctrl_if.sv
// Bundle of the controller's peripheral, CPU-side and register-bus signals.
interface irq_ctrl_if import irq_pkg::*; #(
  parameter int NUM_SRC = NUM_SRC_DEF
);
  logic [NUM_SRC-1:0] src;
  logic               irq_ack;
  logic               irq_ret;
  logic               we;
  logic [1:0]         addr;
  logic [15:0]        wdata;
  logic [15:0]        rdata;
  logic               irq_req;
  logic [15:0]        irq_vector;
  logic               in_irq;
  logic [1:0]         irq_depth;

  modport master (
    output src, irq_ack, irq_ret, we, addr, wdata,
    input  rdata, irq_req, irq_vector, in_irq, irq_depth
  );
  modport slave (
    input  src, irq_ack, irq_ret, we, addr, wdata,
    output rdata, irq_req, irq_vector, in_irq, irq_depth
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: highest set index wins, vld_o flags any request.
module irq_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) begin
        idx_o = IDX_W'(i);
        vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/irq_ctrl.sv
// Nesting interrupt controller: edge-detected pending bits, priority offer, handler stack.
// Define IRQ_CTRL_NEST_EN to allow preemption up to MAX_DEPTH; otherwise depth is capped at 1.
module irq_ctrl import irq_pkg::*; #(
  parameter int NUM_SRC   = NUM_SRC_DEF,
  parameter int MAX_DEPTH = MAX_DEPTH_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SRC-1:0] i_src,
  input  logic               i_irq_ack,
  input  logic               i_irq_ret,
  input  logic               i_we,
  input  logic [1:0]         i_addr,
  input  logic [15:0]        i_wdata,
  output logic [15:0]        o_rdata,
  output logic               o_irq_req,
  output logic [15:0]        o_irq_vector,
  output logic               o_in_irq,
  output logic [1:0]         o_irq_depth
);
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
`ifdef IRQ_CTRL_NEST_EN
  localparam logic [1:0] DEPTH_CAP = 2'(MAX_DEPTH);
`else
  localparam logic [1:0] DEPTH_CAP = (MAX_DEPTH > 0) ? 2'd1 : 2'd0;
`endif

  logic [NUM_SRC-1:0] src_q, en_q, en_d, pend_q, pend_d, clr;
  logic [IDX_W-1:0]   stack_q [4];
  logic [IDX_W-1:0]   stack_d [4];
  logic [1:0]         depth_q, depth_d;
  logic [IDX_W-1:0]   win_idx, top_idx;
  logic               win_vld, preempt, irq_req, take;
  logic               unused_wdata;

  assign unused_wdata = ^i_wdata[15:NUM_SRC];

  irq_prio_enc #(.N(NUM_SRC), .IDX_W(IDX_W)) u_enc (
    .req_i (pend_q & en_q),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  assign top_idx = (depth_q != 2'd0) ? stack_q[depth_q - 2'd1] : '0;
`ifdef IRQ_CTRL_NEST_EN
  assign preempt = win_idx > top_idx;
`else
  assign preempt = 1'b0;
`endif
  assign irq_req = win_vld && (depth_q < DEPTH_CAP) && ((depth_q == 2'd0) || preempt);
  assign take    = i_irq_ack && irq_req;

  // Pop before push so a simultaneous ack/ret replaces the top entry.
  always_comb begin
    en_d    = en_q;
    clr     = '0;
    stack_d = stack_q;
    depth_d = depth_q;
    if (i_we && i_addr == ADDR_ENABLE)  en_d = i_wdata[NUM_SRC-1:0];
    if (i_we && i_addr == ADDR_PENDING) clr  = i_wdata[NUM_SRC-1:0];
    if (take) clr = clr | (NUM_SRC'(1) << win_idx);
    // A fresh edge outranks any clear landing in the same cycle.
    pend_d = (pend_q & ~clr) | (i_src & ~src_q);
    if (i_irq_ret && depth_q != 2'd0) depth_d = depth_q - 2'd1;
    if (take) begin
      stack_d[depth_d] = win_idx;
      depth_d          = depth_d + 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      src_q   <= '0;
      en_q    <= '0;
      pend_q  <= '0;
      depth_q <= '0;
      for (int i = 0; i < 4; i++) stack_q[i] <= '0;
    end else begin
      src_q   <= i_src;
      en_q    <= en_d;
      pend_q  <= pend_d;
      depth_q <= depth_d;
      stack_q <= stack_d;
    end
  end

  always_comb begin
    o_rdata = 16'h0000;
    case (i_addr)
      ADDR_ENABLE:  o_rdata = 16'(en_q);
      ADDR_PENDING: o_rdata = 16'(pend_q);
      ADDR_STATUS:  o_rdata = {8'h00, 4'(top_idx), 2'b00, depth_q};
      default:      o_rdata = 16'h0000;
    endcase
  end

  assign o_irq_req    = irq_req;
  assign o_irq_vector = irq_req ? vec_of(16'(win_idx)) : 16'h0000;
  assign o_in_irq     = depth_q != 2'd0;
  assign o_irq_depth  = depth_q;
endmodule
